dep_scoreboard: RTL

- Generates the `dep_stall` hazard input consumed by the decode stage stall logic of the 5-stage LC-3b pipeline.
- Keeps one pending-write counter per architectural register (R0–R7) and one for the condition codes.
- Counters increment when an instruction issues from decode into EX and decrement when it retires in WB.
- Decode stalls (bubble into EX) while any source operand or the CC it reads has an outstanding writer.

---
 rtl/dep_scoreboard_if.sv | 30 +++
 rtl/dep_scoreboard.sv | 70 +++++++
 2 files changed

// File: rtl/dep_scoreboard_if.sv
// dep_scoreboard_if: decode/issue, writeback-retire and hazard-status signals of the dependency scoreboard.
interface dep_scoreboard_if #(parameter int REG_IDX_W = 3);
    logic                 de_valid;
    logic [REG_IDX_W-1:0] de_sr1;
    logic                 de_sr1_used;
    logic [REG_IDX_W-1:0] de_sr2;
    logic                 de_sr2_used;
    logic [REG_IDX_W-1:0] de_dr;
    logic                 de_dr_used;
    logic                 de_cc_used;
    logic                 de_sets_cc;
    logic                 load_ex;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_dr;
    logic                 wb_dr_used;
    logic                 wb_sets_cc;
    logic                 dep_stall;
    logic                 pending_any;
    logic                 sb_err;
    modport master (
        output de_valid, de_sr1, de_sr1_used, de_sr2, de_sr2_used, de_dr, de_dr_used,
               de_cc_used, de_sets_cc, load_ex, wb_valid, wb_dr, wb_dr_used, wb_sets_cc,
        input  dep_stall, pending_any, sb_err
    );
    modport slave (
        input  de_valid, de_sr1, de_sr1_used, de_sr2, de_sr2_used, de_dr, de_dr_used,
               de_cc_used, de_sets_cc, load_ex, wb_valid, wb_dr, wb_dr_used, wb_sets_cc,
        output dep_stall, pending_any, sb_err
    );
endinterface

// File: rtl/dep_scoreboard.sv
// dep_scoreboard: per-register and CC pending-writer counters producing the decode stall for the LC-3b pipeline.
// Optional DEP_SCOREBOARD_WB_BYPASS_EN: hazard check ignores a writer retiring in the same cycle.
module dep_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int REG_IDX_W = 3,
    parameter int CNT_W     = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    dep_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    cc_q, cc_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] inc_v, dec_v;
    logic                issue, retire, haz, full, cc_inc, cc_dec;
    logic                sr1_busy, sr2_busy, cc_busy, any_q;
    assign retire = sb.wb_valid;
    assign cc_dec = retire & sb.wb_sets_cc;
`ifdef DEP_SCOREBOARD_WB_BYPASS_EN
    // regfile writes before it is read, so a writer retiring now no longer blocks
    assign sr1_busy = cnt_q[sb.de_sr1] > CNT_W'(dec_v[sb.de_sr1]);
    assign sr2_busy = cnt_q[sb.de_sr2] > CNT_W'(dec_v[sb.de_sr2]);
    assign cc_busy  = cc_q > CNT_W'(cc_dec);
`else
    assign sr1_busy = cnt_q[sb.de_sr1] != '0;
    assign sr2_busy = cnt_q[sb.de_sr2] != '0;
    assign cc_busy  = cc_q != '0;
`endif
    assign haz = sb.de_valid & ((sb.de_sr1_used & sr1_busy) | (sb.de_sr2_used & sr2_busy) |
                                (sb.de_cc_used & cc_busy));
    assign full = sb.de_valid & ((sb.de_dr_used & (cnt_q[sb.de_dr] == CNT_MAX)) |
                                 (sb.de_sets_cc & (cc_q == CNT_MAX)));
    assign sb.dep_stall = haz | full;
    assign issue  = sb.de_valid & sb.load_ex & ~sb.dep_stall;
    assign cc_inc = issue & sb.de_sets_cc;
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        any_q = cc_q != '0;
        err_d = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_v[i] = issue & sb.de_dr_used & (sb.de_dr == REG_IDX_W'(i));
            dec_v[i] = retire & sb.wb_dr_used & (sb.wb_dr == REG_IDX_W'(i));
            any_q = any_q | (cnt_q[i] != '0);
            // a retire against an empty counter saturates at zero and flags the error
            err_d = err_d | (dec_v[i] & ~inc_v[i] & (cnt_q[i] == '0));
            cnt_d[i] = (inc_v[i] & ~dec_v[i]) ? cnt_q[i] + 1'b1 :
                       (dec_v[i] & ~inc_v[i] & (cnt_q[i] != '0)) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        err_d = err_d | (cc_dec & ~cc_inc & (cc_q == '0));
        cc_d = (cc_inc & ~cc_dec) ? cc_q + 1'b1 :
               (cc_dec & ~cc_inc & (cc_q != '0)) ? cc_q - 1'b1 : cc_q;
    end
    assign sb.pending_any = any_q;
    assign sb.sb_err      = err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '{default: '0};
            cc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cc_q  <= cc_d;
            err_q <= err_d;
        end
    end
endmodule
